// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot raster front end.
package mandelbrot_pkg;

  // Signed Q16.16 fixed-point coordinate
  typedef logic signed [31:0] fixed_t;

  localparam int unsigned FRAC          = 16;
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;

  // Complex distance per pixel at zoom 0: 3.0/640 in Q16.16
  localparam fixed_t BASE_STEP = 32'sd307;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/raster_origin_calc.sv
// Derives the per-pixel step and the top-left corner of the view from the
// latched centre and zoom, using shifts and adds only.
module raster_origin_calc
  import mandelbrot_pkg::*;
(
  input  fixed_t     center_re,
  input  fixed_t     center_im,
  input  logic [3:0] zoom,
  output fixed_t     step,
  output fixed_t     real_min,
  output fixed_t     imag_max
);

  fixed_t step_raw;

  // Step from zoom (clamped to 1 LSB) and half-screen offsets 320*step / 240*step
  always_comb begin
    step_raw = BASE_STEP >>> zoom;
    if (step_raw == 32'sd0) begin
      step = 32'sd1;
    end else begin
      step = step_raw;
    end
    real_min = center_re - (step <<< 8) - (step <<< 6);
    imag_max = center_im + (step <<< 8) - (step <<< 4);
  end

endmodule

// File: rtl/raster_scheduler.sv
// Walks the screen in raster order and hands one (x, y, re, im) work item per
// pixel to the iteration engine over a valid/ready handshake. Coordinates are
// stepped incrementally; the view origin is computed once per frame.
module raster_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int unsigned ROW_PIXELS = SCREEN_WIDTH,
  parameter int unsigned FRAME_ROWS = SCREEN_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  fixed_t      cfg_center_re,
  input  fixed_t      cfg_center_im,
  input  logic [3:0]  cfg_zoom,
  output logic        busy,
  output logic        frame_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output fixed_t      real_part,
  output fixed_t      im_part,
  output logic        last
);

  localparam logic [9:0] X_LAST = 10'(ROW_PIXELS - 1);
  localparam logic [8:0] Y_LAST = 9'(FRAME_ROWS - 1);

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       out_valid_q, out_valid_d;
  logic       last_q, last_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  fixed_t     re_q, re_d;
  fixed_t     im_q, im_d;
  fixed_t     step_q, step_d;
  fixed_t     real_min_q, real_min_d;
  fixed_t     cfg_re_q, cfg_re_d;
  fixed_t     cfg_im_q, cfg_im_d;
  logic [3:0] cfg_zoom_q, cfg_zoom_d;

  fixed_t     calc_step;
  fixed_t     calc_real_min;
  fixed_t     calc_imag_max;
  logic       xfer;
  logic [9:0] nx;
  logic [8:0] ny;

  raster_origin_calc u_origin (
    .center_re (cfg_re_q),
    .center_im (cfg_im_q),
    .zoom      (cfg_zoom_q),
    .step      (calc_step),
    .real_min  (calc_real_min),
    .imag_max  (calc_imag_max)
  );

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    last_d       = last_q;
    x_d          = x_q;
    y_d          = y_q;
    re_d         = re_q;
    im_d         = im_q;
    step_d       = step_q;
    real_min_d   = real_min_q;
    cfg_re_d     = cfg_re_q;
    cfg_im_d     = cfg_im_q;
    cfg_zoom_d   = cfg_zoom_q;
    xfer         = out_valid_q && out_ready;
    nx           = x_q;
    ny           = y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_re_d   = cfg_center_re;
          cfg_im_d   = cfg_center_im;
          cfg_zoom_d = cfg_zoom;
          busy_d     = 1'b1;
          state_d    = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        step_d      = calc_step;
        real_min_d  = calc_real_min;
        x_d         = 10'd0;
        y_d         = 9'd0;
        re_d        = calc_real_min;
        im_d        = calc_imag_max;
        last_d      = (X_LAST == 10'd0) && (Y_LAST == 9'd0);
        out_valid_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (xfer) begin
          if (last_q) begin
            out_valid_d  = 1'b0;
            last_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            if (x_q == X_LAST) begin
              nx   = 10'd0;
              ny   = y_q + 9'd1;
              re_d = real_min_q;
              im_d = im_q - step_q;
            end else begin
              nx   = x_q + 10'd1;
              ny   = y_q;
              re_d = re_q + step_q;
            end
            x_d    = nx;
            y_d    = ny;
            last_d = (nx == X_LAST) && (ny == Y_LAST);
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 9'd0;
      re_q         <= 32'sd0;
      im_q         <= 32'sd0;
      step_q       <= 32'sd0;
      real_min_q   <= 32'sd0;
      cfg_re_q     <= 32'sd0;
      cfg_im_q     <= 32'sd0;
      cfg_zoom_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      last_q       <= last_d;
      x_q          <= x_d;
      y_q          <= y_d;
      re_q         <= re_d;
      im_q         <= im_d;
      step_q       <= step_d;
      real_min_q   <= real_min_d;
      cfg_re_q     <= cfg_re_d;
      cfg_im_q     <= cfg_im_d;
      cfg_zoom_q   <= cfg_zoom_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign last       = last_q;
  assign x          = x_q;
  assign y          = y_q;
  assign real_part  = re_q;
  assign im_part    = im_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Scoreboard bench for raster_scheduler. Full 640-pixel rows are kept so the
// row-wrap and end-of-row coordinates match the full-screen values; the frame
// height is shortened to keep each frame a few thousand cycles.
module tb_raster_scheduler;

  localparam int W = 640;
  localparam int H = 4;
  localparam int N = W * H;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic signed [31:0] cfg_center_re, cfg_center_im;
  logic [3:0]         cfg_zoom;
  logic               busy, frame_done, out_valid, out_last;
  logic [9:0]         x;
  logic [8:0]         y;
  logic signed [31:0] real_part, im_part;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;

  typedef struct {
    logic [9:0]         x;
    logic [8:0]         y;
    logic signed [31:0] re;
    logic signed [31:0] im;
    logic               last;
  } item_t;

  item_t exp_q[$];
  item_t mon_e, mon_cur, held;
  bit    hold_pending = 1'b0;
  int    item_idx = 0;

  raster_scheduler #(.ROW_PIXELS(W), .FRAME_ROWS(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_center_re (cfg_center_re),
    .cfg_center_im (cfg_center_im),
    .cfg_zoom      (cfg_zoom),
    .busy          (busy),
    .frame_done    (frame_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .x             (x),
    .y             (y),
    .real_part     (real_part),
    .im_part       (im_part),
    .last          (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected item for every pixel: re = rmin + col*step, im = imax - row*step
  task automatic push_frame(input int rmin, input int imax, input int st);
    item_t it;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        it.x    = 10'(c);
        it.y    = 9'(r);
        it.re   = rmin + c * st;
        it.im   = imax - r * st;
        it.last = (c == W - 1) && (r == H - 1);
        exp_q.push_back(it);
      end
    end
  endtask

  // Monitor: pops the scoreboard on each transfer and checks held items stay stable
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (frame_done) fd_count++;
      mon_cur.x    = x;
      mon_cur.y    = y;
      mon_cur.re   = real_part;
      mon_cur.im   = im_part;
      mon_cur.last = out_last;
      if (hold_pending) begin
        n_checks++;
        if (!out_valid || mon_cur !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0b x=%0d y=%0d re=%0d im=%0d, expected v=1 x=%0d y=%0d re=%0d im=%0d",
                   out_valid, x, y, real_part, im_part, held.x, held.y, held.re, held.im);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL item[%0d]: got unexpected transfer x=%0d y=%0d, expected none", item_idx, x, y);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_cur !== mon_e) begin
            n_fail++;
            $display("FAIL item[%0d]: got x=%0d y=%0d re=%0d im=%0d last=%0b, expected x=%0d y=%0d re=%0d im=%0d last=%0b",
                     item_idx, x, y, real_part, im_part, out_last,
                     mon_e.x, mon_e.y, mon_e.re, mon_e.im, mon_e.last);
          end
        end
        item_idx++;
      end
      hold_pending = out_valid && !out_ready;
      held = mon_cur;
    end
  end

  // Pulse start (called just after a rising edge); returns one cycle into RUN
  task automatic do_start(input int cre, input int cim, input logic [3:0] z);
    cfg_center_re = cre;
    cfg_center_im = cim;
    cfg_zoom      = z;
    start         = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    cfg_center_re = 32'sh0007_0000;
    cfg_center_im = -32'sh0003_0000;
    cfg_zoom      = 4'd2;
    @(negedge clk);
    check("setup_valid_low", out_valid, 0);
    check("setup_busy_high", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit bp, input int mid_at, input int abort_at,
                           input bit start_in_done, input int fd_before);
    int cycles   = 0;
    int xfers    = 0;
    bit done     = 1'b0;
    bit mid_done = 1'b0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check("first_valid_latency", out_valid, 1);
      if (out_valid) cycles++;
      if (out_valid && out_ready) begin
        xfers++;
        if (out_last) done = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = bp ? ($urandom_range(99, 0) < 30) : 1'b1;
      start = 1'b0;
      if (mid_at > 0 && xfers >= mid_at && !mid_done) begin
        cfg_center_re = 32'sh0001_0000;
        cfg_zoom      = 4'd3;
        start         = 1'b1;
        mid_done      = 1'b1;
      end
      if (abort_at > 0 && xfers == abort_at) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid_low", out_valid, 0);
        check("abort_busy_low", busy, 0);
        check("abort_x_zero", x, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_frame_done", fd_count, fd_before);
        @(posedge clk); #1;
        return;
      end
    end
    check("frame_completed", done, 1);
    if (!done) begin
      start = 1'b0;
      exp_q.delete();
      return;
    end
    if (!bp) check("valid_cycles", cycles, N);
    check("transfers", xfers, N);
    start = start_in_done;
    @(negedge clk);
    check("frame_done_pulse", frame_done, 1);
    check("done_valid_low", out_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("frame_done_single", frame_done, 0);
    check("busy_after_done", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("frame_done_count", fd_count, fd_before + 1);
    check("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    out_ready     = 1'b0;
    cfg_center_re = 32'sd0;
    cfg_center_im = 32'sd0;
    cfg_zoom      = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_last", out_last, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_real", real_part, 0);
    check("rst_imag", im_part, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame A: centre -0.5+0i, zoom 0, full rate, start pulsed mid-frame
    out_ready = 1'b1;
    push_frame(-131008, 73680, 307);
    do_start(-32768, 0, 4'd0);
    run_frame(1'b0, 1000, 0, 1'b0, fd_count);

    // Frame B: same view under 30% backpressure
    out_ready = 1'b0;
    push_frame(-131008, 73680, 307);
    do_start(-32768, 0, 4'd0);
    run_frame(1'b1, 0, 0, 1'b0, fd_count);

    // Frame C: zoom 8 gives step 1; start during DONE must be ignored
    out_ready = 1'b1;
    push_frame(-320, 240, 1);
    do_start(0, 0, 4'd8);
    run_frame(1'b0, 0, 0, 1'b1, fd_count);

    // Frame D: zoom 15 shifts to zero, clamped to step 1
    push_frame(-320, 240, 1);
    do_start(0, 0, 4'd15);
    run_frame(1'b0, 0, 0, 1'b0, fd_count);

    // Frame E: reset after 1000 transfers aborts without frame_done
    out_ready = 1'b1;
    push_frame(-131008, 73680, 307);
    do_start(-32768, 0, 4'd0);
    run_frame(1'b0, 0, 1000, 1'b0, fd_count);

    // Frame F: restart after the abort begins again at (0,0)
    out_ready = 1'b1;
    push_frame(-131008, 73680, 307);
    do_start(-32768, 0, 4'd0);
    run_frame(1'b0, 0, 0, 1'b0, fd_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
